// File: rtl/act_pwl_simd_if.sv
// Beat-level handshake bundle for the piecewise-linear sigmoid/tanh SIMD block.
// The master drives input beats and output backpressure; the slave is the block.
interface act_pwl_simd_if #(
  parameter int LANES = 4,
  parameter int DW    = 16
);
  logic                  valid_in;
  logic                  ready_in;
  logic                  mode_in;
  logic [LANES*DW-1:0]   x_in;
  logic                  valid_out;
  logic                  ready_out;
  logic [LANES*DW-1:0]   y_out;

  modport master (
    output valid_in, mode_in, x_in, ready_out,
    input  ready_in, valid_out, y_out
  );

  modport slave (
    input  valid_in, mode_in, x_in, ready_out,
    output ready_in, valid_out, y_out
  );
endinterface

// File: rtl/act_pwl_simd.sv
// LANES-wide piecewise-linear sigmoid/tanh on signed Q5.11 samples, 3-stage pipeline
// with a single global stall driven by output backpressure (no bubble collapsing).
module act_pwl_simd #(
  parameter int LANES = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  act_pwl_simd_if.slave bus
);
  localparam logic signed [DW-1:0] MAXV    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] ONE     = DW'(2048);
  localparam logic signed [DW-1:0] SEG_HI  = DW'(10240);
  localparam logic signed [DW-1:0] SEG_MID = DW'(4864);
  localparam logic signed [DW-1:0] SEG_LO  = DW'(2048);
  localparam logic signed [DW-1:0] OFS_HI  = DW'(1728);
  localparam logic signed [DW-1:0] OFS_MID = DW'(1280);
  localparam logic signed [DW-1:0] OFS_LO  = DW'(1024);

  // tanh(x) = 2*sigmoid(2x) - 1, so tanh lanes evaluate the sigmoid curve at 2x.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [DW-1:0] x,
                                                     input logic                 tanh);
    logic signed [DW:0] t;
    t = {x, 1'b0};
    if (!tanh)
      return x;
    if (t[DW] != t[DW-1])
      return t[DW] ? MINV : MAXV;
    return $signed(t[DW-1:0]);
  endfunction

  function automatic logic signed [DW-1:0] abs_sat(input logic signed [DW-1:0] v);
    if (v == MINV)
      return MAXV;
    return v[DW-1] ? -v : v;
  endfunction

  function automatic logic signed [DW-1:0] seg_eval(input logic signed [DW-1:0] a);
    if (a >= SEG_HI)
      return ONE;
    else if (a >= SEG_MID)
      return (a >>> 5) + OFS_HI;
    else if (a >= SEG_LO)
      return (a >>> 3) + OFS_MID;
    return (a >>> 2) + OFS_LO;
  endfunction

  function automatic logic signed [DW-1:0] sym_map(input logic signed [DW-1:0] s,
                                                   input logic                 neg,
                                                   input logic                 tanh);
    logic signed [DW-1:0] sp;
    sp = neg ? (ONE - s) : s;
    return tanh ? ((sp <<< 1) - ONE) : sp;
  endfunction

  logic                 en;
  logic                 vld_p1, vld_p2, vld_p3;
  logic                 mode_p1, mode_p2;
  logic [LANES-1:0]     neg_p1, neg_p2;
  logic signed [DW-1:0] a_p1 [LANES];
  logic signed [DW-1:0] s_p2 [LANES];
  logic [LANES*DW-1:0]  y_p3;

  logic signed [DW-1:0] v_nxt [LANES];
  logic signed [DW-1:0] a_nxt [LANES];
  logic [LANES-1:0]     neg_nxt;
  logic signed [DW-1:0] s_nxt [LANES];
  logic [LANES*DW-1:0]  y_nxt;

  assign en            = !vld_p3 || bus.ready_out;
  assign bus.ready_in  = en;
  assign bus.valid_out = vld_p3;
  assign bus.y_out     = y_p3;

  // S1: scale and fold onto the positive half, remembering the sign
  always_comb begin
    v_nxt   = '{default: '0};
    a_nxt   = '{default: '0};
    neg_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      v_nxt[k]   = scale_sat($signed(bus.x_in[k*DW +: DW]), bus.mode_in);
      neg_nxt[k] = v_nxt[k][DW-1];
      a_nxt[k]   = abs_sat(v_nxt[k]);
    end
  end

  // S2: segment select and linear evaluate
  always_comb begin
    s_nxt = '{default: '0};
    for (int k = 0; k < LANES; k++)
      s_nxt[k] = seg_eval(a_p1[k]);
  end

  // S3: mirror negative inputs and map to tanh range
  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < LANES; k++)
      y_nxt[k*DW +: DW] = sym_map(s_p2[k], neg_p2[k], mode_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      y_p3   <= '0;
    end else if (en) begin
      vld_p1 <= bus.valid_in;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      y_p3   <= y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mode_p1 <= bus.mode_in;
      neg_p1  <= neg_nxt;
      a_p1    <= a_nxt;
      mode_p2 <= mode_p1;
      neg_p2  <= neg_p1;
      s_p2    <= s_nxt;
    end
  end
endmodule

// File: tb/tb_act_pwl_simd.sv
// Directed vector table, backpressured stream against an integer reference model,
// and a mid-stream reset sequence for act_pwl_simd.
module tb_act_pwl_simd;
  localparam int LANES = 4;
  localparam int DW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_pwl_simd_if #(.LANES(LANES), .DW(DW)) bus ();
  act_pwl_simd #(.LANES(LANES), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       name;
    logic        mode;
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  vec_t tbl [7];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Integer reference: tanh(x) = 2*sig(2x)-1 evaluated on the PWL sigmoid.
  function automatic logic [15:0] model(input logic [15:0] x, input logic mode);
    int v, a, s, sm, y;
    v = int'($signed(x));
    if (mode) begin
      v = 2 * v;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
    end
    a = (v < 0) ? -v : v;
    if (a > 32767) a = 32767;
    if (a >= 10240)     s = 2048;
    else if (a >= 4864) s = a / 32 + 1728;
    else if (a >= 2048) s = a / 8 + 1280;
    else                s = a / 4 + 1024;
    sm = (v < 0) ? 2048 - s : s;
    y  = mode ? 2 * sm - 2048 : sm;
    return y[15:0];
  endfunction

  function automatic logic [63:0] model_beat(input logic [63:0] x, input logic mode);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*16 +: 16] = model(x[k*16 +: 16], mode);
    return r;
  endfunction

  function automatic logic [63:0] stream_x(input int i);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*16 +: 16] = 16'((i - 10) * 2048 + k * 300);
    return r;
  endfunction

  task automatic send_and_check(input string name, input logic mode,
                                input logic [63:0] x, input logic [63:0] y);
    int cyc;
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.mode_in   = mode;
    bus.x_in      = x;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    cyc = 1;
    while (!bus.valid_out && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd3);
    check(name, bus.y_out, y);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, got, held, cyc, idle_hits;
    logic        in_x;
    logic [63:0] held_y;
    logic [63:0] qexp [$];

    // x and y listed lane3..lane0
    tbl[0] = '{"sig basic",   1'b0, {16'h0000, 16'h0800, 16'hF800, 16'h1400}, {16'h0400, 16'h0600, 16'h0200, 16'h0760}};
    tbl[1] = '{"tanh basic",  1'b1, {16'h0000, 16'h0800, 16'h5000, 16'hB000}, {16'h0000, 16'h0600, 16'h0800, 16'hF800}};
    tbl[2] = '{"sig sat",     1'b0, {16'h8000, 16'h7FFF, 16'h0000, 16'h0000}, {16'h0000, 16'h0800, 16'h0400, 16'h0400}};
    tbl[3] = '{"tanh sat",    1'b1, {16'h4000, 16'h0000, 16'h0000, 16'h0000}, {16'h0800, 16'h0000, 16'h0000, 16'h0000}};
    tbl[4] = '{"sig bounds",  1'b0, {16'h2800, 16'h27FF, 16'h1300, 16'h12FF}, {16'h0800, 16'h07FF, 16'h0758, 16'h075F}};
    tbl[5] = '{"sig neg",     1'b0, {16'h07FF, 16'hF801, 16'hD800, 16'hFFFF}, {16'h05FF, 16'h0201, 16'h0000, 16'h0400}};
    tbl[6] = '{"tanh mixed",  1'b1, {16'h0400, 16'hFC00, 16'h1400, 16'h0980}, {16'h0400, 16'hFC00, 16'h0800, 16'h06B0}};

    bus.valid_in  = 1'b0;
    bus.mode_in   = 1'b0;
    bus.x_in      = '0;
    bus.ready_out = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset valid_out", 64'(bus.valid_out), 64'd0);
    check("reset ready_in", 64'(bus.ready_in), 64'd1);
    check("reset y_out", bus.y_out, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      send_and_check(tbl[i].name, tbl[i].mode, tbl[i].x, tbl[i].y);

    // Backpressured stream with bubbles and alternating mode
    sent = 0; got = 0; held = 0; cyc = 0; held_y = '0;
    bus.valid_in = 1'b0;
    @(posedge clk); #1;
    while (got < 20 && cyc < 2000) begin
      bus.ready_out = ($urandom_range(0, 2) != 0);
      if (!bus.valid_in && sent < 20 && $urandom_range(0, 3) != 0) begin
        bus.valid_in = 1'b1;
        bus.mode_in  = sent[0];
        bus.x_in     = stream_x(sent);
      end
      @(negedge clk);
      if (held != 0) begin
        check("stall valid", 64'(bus.valid_out), 64'd1);
        check("stall data", bus.y_out, held_y);
      end
      if (bus.valid_out) begin
        if (bus.ready_out) begin
          if (qexp.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL stream extra beat: got %h expected none", bus.y_out);
          end else begin
            check("stream beat", bus.y_out, qexp.pop_front());
          end
          got++;
          held = 0;
        end else begin
          held   = 1;
          held_y = bus.y_out;
        end
      end else begin
        held = 0;
      end
      in_x = bus.valid_in && bus.ready_in;
      if (in_x)
        qexp.push_back(model_beat(bus.x_in, bus.mode_in));
      @(posedge clk); #1;
      cyc++;
      if (in_x) begin
        sent++;
        bus.valid_in = 1'b0;
      end
    end
    check("stream count", 64'(got), 64'd20);
    check("stream leftover", 64'(qexp.size()), 64'd0);

    // Reset with three beats in flight
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    bus.mode_in   = 1'b0;
    bus.x_in      = {16'h0800, 16'h0800, 16'h0800, 16'h0800};
    repeat (3) @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst valid_out", 64'(bus.valid_out), 64'd0);
    check("midrst ready_in", 64'(bus.ready_in), 64'd1);
    check("midrst y_out", bus.y_out, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.valid_out) idle_hits++;
    end
    check("post-reset idle", 64'(idle_hits), 64'd0);
    send_and_check("post-reset beat", 1'b1,
                   {16'h0000, 16'h0800, 16'h5000, 16'hB000},
                   {16'h0000, 16'h0600, 16'h0800, 16'hF800});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
